// File: rtl/hdmi_timing_pattern_gen_if.sv
// Video output bus from the timing/pattern generator to the HDMI transmitter.
interface hdmi_timing_pattern_gen_if #(
  parameter int unsigned COORD_W = 12
);
  logic               hsync;
  logic               vsync;
  logic               data_enable;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               frame_start;
  logic               line_start;
  logic [23:0]        rgb_data;

  // Generator side drives the bus.
  modport master (
    output hsync, vsync, data_enable, pix_x, pix_y, frame_start, line_start, rgb_data
  );

  // Transmitter side consumes it.
  modport slave (
    input hsync, vsync, data_enable, pix_x, pix_y, frame_start, line_start, rgb_data
  );
endinterface

// File: rtl/hdmi_timing_pattern_gen.sv
// Parametrised video timing generator with a frame-synchronous test-pattern source.
// All outputs are registered one cycle after the h/v counter state they decode.
module hdmi_timing_pattern_gen #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BP       = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FP       = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 20,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1,
  parameter int unsigned COORD_W    = 12,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       run,
  input  logic [1:0]                 pattern_sel,
  input  logic [23:0]                solid_rgb,
  hdmi_timing_pattern_gen_if.master  vid
);

  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t      h_q, v_q;
  logic [1:0]  pat_q;
  logic [23:0] col_q;

  logic        at_origin;
  logic [1:0]  pat_eff;
  logic [23:0] col_eff;
  logic        de_d, hs_act, vs_act;
  logic [2:0]  bar_idx;
  logic [23:0] rgb_d;

  logic        hsync_q, vsync_q, de_q, fs_q, ls_q;
  coord_t      x_q, y_q;
  logic [23:0] rgb_q;

  // Raster counters; held at the origin while run is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!run) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == H_LAST) begin
      h_q <= '0;
      v_q <= (v_q == V_LAST) ? '0 : v_q + coord_t'(1);
    end else begin
      h_q <= h_q + coord_t'(1);
    end
  end

  assign at_origin = (h_q == '0) && (v_q == '0);
  // Pixel (0,0) already uses the freshly sampled selection, so the new pattern starts cleanly.
  assign pat_eff   = at_origin ? pattern_sel : pat_q;
  assign col_eff   = at_origin ? solid_rgb : col_q;

  // Shadow pattern/colour, sampled only at the frame origin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_q <= '0;
      col_q <= '0;
    end else if (run && at_origin) begin
      pat_q <= pattern_sel;
      col_q <= solid_rgb;
    end
  end

  // Decode the counter state into sync, enable and pixel colour.
  always_comb begin
    de_d   = (h_q < H_ACT) && (v_q < V_ACT);
    hs_act = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_act = (v_q >= VS_BEG) && (v_q < VS_END);

    // Constant thresholds k*BAR_W; anything past the 8th boundary stays in the last bar.
    bar_idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h_q >= coord_t'(k * BAR_W)) bar_idx = 3'(k);
    end

    rgb_d = '0;
    unique case (pat_eff)
      2'd0: rgb_d = col_eff;
      2'd1: begin
        unique case (bar_idx)
          3'd0: rgb_d = 24'hFFFFFF;
          3'd1: rgb_d = 24'hFFFF00;
          3'd2: rgb_d = 24'h00FFFF;
          3'd3: rgb_d = 24'h00FF00;
          3'd4: rgb_d = 24'hFF00FF;
          3'd5: rgb_d = 24'hFF0000;
          3'd6: rgb_d = 24'h0000FF;
          3'd7: rgb_d = 24'h000000;
        endcase
      end
      2'd2: rgb_d = (h_q[CHECK_LOG2] ^ v_q[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
      2'd3: rgb_d = {h_q[7:0], h_q[7:0], h_q[7:0]};
    endcase
    if (!de_d) rgb_d = '0;
  end

  // Output register stage; idles at the reset levels while run is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      rgb_q   <= '0;
    end else if (!run) begin
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hs_act ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_q <= vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      de_q    <= de_d;
      x_q     <= de_d ? h_q : '0;
      y_q     <= de_d ? v_q : '0;
      fs_q    <= at_origin;
      ls_q    <= (h_q == '0) && (v_q < V_ACT);
      rgb_q   <= rgb_d;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.data_enable = de_q;
  assign vid.pix_x       = x_q;
  assign vid.pix_y       = y_q;
  assign vid.frame_start = fs_q;
  assign vid.line_start  = ls_q;
  assign vid.rgb_data    = rgb_q;

endmodule

// File: tb/tb_hdmi_timing_pattern_gen.sv
// Bench for hdmi_timing_pattern_gen: four parameter sets share one stimulus stream and are
// checked every cycle against an arithmetic raster model, plus hand-computed literals.
module tb_hdmi_timing_pattern_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        ls;
    logic [23:0] rgb;
  } vo_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int chk;
  } cfg_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hdmi_timing_pattern_gen_if #(.COORD_W(12)) vif0 ();
  hdmi_timing_pattern_gen_if #(.COORD_W(12)) vif1 ();
  hdmi_timing_pattern_gen_if #(.COORD_W(12)) vif2 ();
  hdmi_timing_pattern_gen_if #(.COORD_W(12)) vif3 ();

  // 720p defaults
  hdmi_timing_pattern_gen u_dut0 (
    .clock(clk), .reset(reset), .run(run), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vid(vif0)
  );

  // Odd active width: last bar absorbs the remainder
  hdmi_timing_pattern_gen #(.H_ACTIVE(1283)) u_dut1 (
    .clock(clk), .reset(reset), .run(run), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vid(vif1)
  );

  // Tiny raster
  hdmi_timing_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CHECK_LOG2(1)
  ) u_dut2 (
    .clock(clk), .reset(reset), .run(run), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vid(vif2)
  );

  // Medium raster, inverted sync polarities
  hdmi_timing_pattern_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(5),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CHECK_LOG2(5)
  ) u_dut3 (
    .clock(clk), .reset(reset), .run(run), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vid(vif3)
  );

  function automatic cfg_t get_cfg(input int d);
    case (d)
      0:       return '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1, 5};
      1:       return '{1283, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1, 5};
      2:       return '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 1};
      default: return '{64, 4, 6, 6, 40, 2, 3, 5, 1'b0, 1'b0, 5};
    endcase
  endfunction

  function automatic vo_t get_act(input int d);
    case (d)
      0: return {vif0.hsync, vif0.vsync, vif0.data_enable, vif0.pix_x, vif0.pix_y,
                 vif0.frame_start, vif0.line_start, vif0.rgb_data};
      1: return {vif1.hsync, vif1.vsync, vif1.data_enable, vif1.pix_x, vif1.pix_y,
                 vif1.frame_start, vif1.line_start, vif1.rgb_data};
      2: return {vif2.hsync, vif2.vsync, vif2.data_enable, vif2.pix_x, vif2.pix_y,
                 vif2.frame_start, vif2.line_start, vif2.rgb_data};
      default: return {vif3.hsync, vif3.vsync, vif3.data_enable, vif3.pix_x, vif3.pix_y,
                       vif3.frame_start, vif3.line_start, vif3.rgb_data};
    endcase
  endfunction

  function automatic vo_t idle_px(input cfg_t c);
    vo_t o = '0;
    o.hs = !c.hp;
    o.vs = !c.vp;
    return o;
  endfunction

  // What the bus must show for raster position (h,v) under the given pattern.
  function automatic vo_t model_px(input cfg_t c, input int h, input int v, input logic [1:0] pat,
                                   input logic [23:0] col);
    vo_t o = '0;
    int bar;
    logic [7:0] r8;
    o.de = (h < c.ha) && (v < c.va);
    o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
    o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : !c.vp;
    o.x  = o.de ? 12'(h) : 12'd0;
    o.y  = o.de ? 12'(v) : 12'd0;
    o.fs = (h == 0) && (v == 0);
    o.ls = (h == 0) && (v < c.va);
    if (o.de) begin
      case (pat)
        2'd0: o.rgb = col;
        2'd1: begin
          bar = h / (c.ha / 8);
          if (bar > 7) bar = 7;
          case (bar)
            0: o.rgb = 24'hFFFFFF;
            1: o.rgb = 24'hFFFF00;
            2: o.rgb = 24'h00FFFF;
            3: o.rgb = 24'h00FF00;
            4: o.rgb = 24'hFF00FF;
            5: o.rgb = 24'hFF0000;
            6: o.rgb = 24'h0000FF;
            default: o.rgb = 24'h000000;
          endcase
        end
        2'd2: o.rgb = ((((h >> c.chk) ^ (v >> c.chk)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
        default: begin
          r8 = 8'(h % 256);
          o.rgb = {r8, r8, r8};
        end
      endcase
    end
    return o;
  endfunction

  task automatic cmp_vo(input string name, input int d, input vo_t a, input vo_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b rgb=%h want hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b rgb=%h",
               name, d, $time, a.hs, a.vs, a.de, a.x, a.y, a.fs, a.ls, a.rgb,
               e.hs, e.vs, e.de, e.x, e.y, e.fs, e.ls, e.rgb);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Model: n counts run cycles since the last restart; position is n modulo the frame size.
  bit          m_active = 1'b0;
  int          m_n = 0;
  logic [1:0]  m_pat[4];
  logic [23:0] m_col[4];

  initial begin
    for (int d = 0; d < 4; d++) begin
      m_pat[d] = '0;
      m_col[d] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (reset || !run) begin
        m_active = 1'b0;
        for (int d = 0; d < 4; d++) begin
          if (reset) begin
            m_pat[d] = '0;
            m_col[d] = '0;
          end
          cmp_vo("cycle_idle", d, get_act(d), idle_px(get_cfg(d)));
        end
      end else begin
        m_n = m_active ? m_n + 1 : 0;
        m_active = 1'b1;
        for (int d = 0; d < 4; d++) begin
          cfg_t c;
          int ht, vt, p;
          c  = get_cfg(d);
          ht = c.ha + c.hf + c.hs + c.hb;
          vt = c.va + c.vf + c.vs + c.vb;
          p  = m_n % (ht * vt);
          if (p == 0) begin
            m_pat[d] = pattern_sel;
            m_col[d] = solid_rgb;
          end
          cmp_vo("cycle_run", d, get_act(d), model_px(c, p % ht, p / ht, m_pat[d], m_col[d]));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Bounded wait until dut3 shows active pixel (x,y).
  task automatic wait_px3(input int x, input int y, input int limit, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step(1);
      if (vif3.data_enable && vif3.pix_x == 12'(x) && vif3.pix_y == 12'(y)) ok = 1'b1;
    end
    chk_val(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int de0 = 0, hsc0 = 0, hs0_start = -1, ls0 = -1, ls0b = 0;
    logic [23:0] rgb159 = 0, rgb160 = 0, rgb1279 = 0;
    logic [11:0] x1279 = 0;
    logic [23:0] b1119 = 0, b1120 = 0, b1282 = 0;
    int blk1 = 0, blue1 = 0;
    int de2 = 0, vs2 = 0, vs2_start = -1, fs2b = -1;
    int de3 = 0, vs3 = 0, vs3_start = -1, hs3_start = -1, fs3b = -1;
    logic [13:0] de_vec, hs_vec, vs_vec;

    reset = 1'b1;
    run = 1'b0;
    pattern_sel = 2'd1;
    solid_rgb = 24'h123456;
    step(3);
    chk_val("rst_hsync_pol1", 32'(vif0.hsync), 32'd0);
    chk_val("rst_vsync_pol1", 32'(vif0.vsync), 32'd0);
    chk_val("rst_hsync_pol0", 32'(vif3.hsync), 32'd1);
    chk_val("rst_vsync_pol0", 32'(vif3.vsync), 32'd1);
    chk_val("rst_de", 32'(vif0.data_enable), 32'd0);
    chk_val("rst_rgb", 32'(vif0.rgb_data), 32'd0);

    // Free run from release; measure line/frame structure.
    reset = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      step(1);
      if (i == 0) begin
        chk_val("first_fs", 32'(vif0.frame_start), 32'd1);
        chk_val("first_de", 32'(vif0.data_enable), 32'd1);
        chk_val("first_xy", {vif0.pix_x, vif0.pix_y}, 32'd0);
        chk_val("first_rgb", 32'(vif0.rgb_data), 32'hFFFFFF);
      end
      if (i < 1650) begin
        de0 += int'(vif0.data_enable);
        hsc0 += int'(vif0.hsync);
        if (vif0.hsync && hs0_start < 0) hs0_start = i;
        if (vif0.line_start && ls0 < 0) ls0 = i;
      end
      if (i == 1650) ls0b = int'(vif0.line_start);
      if (i == 159) rgb159 = vif0.rgb_data;
      if (i == 160) rgb160 = vif0.rgb_data;
      if (i == 1279) begin
        rgb1279 = vif0.rgb_data;
        x1279 = vif0.pix_x;
      end
      if (i == 1119) b1119 = vif1.rgb_data;
      if (i == 1120) b1120 = vif1.rgb_data;
      if (i == 1282) b1282 = vif1.rgb_data;
      if (i < 1283 && vif1.rgb_data == 24'h000000) blk1++;
      if (i < 1283 && vif1.rgb_data == 24'h0000FF) blue1++;
      if (i < 98) begin
        de2 += int'(vif2.data_enable);
        vs2 += int'(vif2.vsync);
        if (vif2.vsync && vs2_start < 0) vs2_start = i;
      end
      if (i > 0 && vif2.frame_start && fs2b < 0) fs2b = i;
      if (i < 4000) begin
        de3 += int'(vif3.data_enable);
        if (!vif3.vsync) vs3++;
        if (!vif3.vsync && vs3_start < 0) vs3_start = i;
        if (!vif3.hsync && hs3_start < 0) hs3_start = i;
      end
      if (i > 0 && vif3.frame_start && fs3b < 0) fs3b = i;
    end
    chk_val("de_per_line", 32'(de0), 32'd1280);
    chk_val("hsync_width", 32'(hsc0), 32'd40);
    chk_val("hsync_offset", 32'(hs0_start - ls0), 32'd1390);
    chk_val("line2_start", 32'(ls0b), 32'd1);
    chk_val("bar_x159", 32'(rgb159), 32'hFFFFFF);
    chk_val("bar_x160", 32'(rgb160), 32'hFFFF00);
    chk_val("bar_x1279", 32'(rgb1279), 32'h000000);
    chk_val("pix_x1279", 32'(x1279), 32'd1279);
    chk_val("odd_x1119", 32'(b1119), 32'h0000FF);
    chk_val("odd_x1120", 32'(b1120), 32'h000000);
    chk_val("odd_x1282", 32'(b1282), 32'h000000);
    chk_val("odd_last_bar_w", 32'(blk1), 32'd163);
    chk_val("odd_blue_bar_w", 32'(blue1), 32'd160);
    chk_val("small_de_frame", 32'(de2), 32'd32);
    chk_val("small_vs_width", 32'(vs2), 32'd14);
    chk_val("small_vs_start", 32'(vs2_start), 32'd70);
    chk_val("small_frame_per", 32'(fs2b), 32'd98);
    chk_val("med_de_frame", 32'(de3), 32'd2560);
    chk_val("med_vs_width", 32'(vs3), 32'd240);
    chk_val("med_vs_start", 32'(vs3_start), 32'd3360);
    chk_val("med_hs_start", 32'(hs3_start), 32'd68);
    chk_val("med_frame_per", 32'(fs3b), 32'd4000);

    // Frame-synchronous pattern switch on the medium raster.
    pattern_sel = 2'd0;
    solid_rgb = 24'h123456;
    wait_px3(0, 0, 5000, "wait_frame_a");
    chk_val("solid_at_origin", 32'(vif3.rgb_data), 32'h123456);
    wait_px3(0, 30, 4000, "wait_line30");
    pattern_sel = 2'd2;
    wait_px3(5, 35, 1000, "wait_line35");
    chk_val("no_midframe_switch", 32'(vif3.rgb_data), 32'h123456);
    wait_px3(0, 0, 5000, "wait_frame_b");
    chk_val("checker_0_0", 32'(vif3.rgb_data), 32'hFFFFFF);
    step(32);
    chk_val("checker_32_x", 32'(vif3.pix_x), 32'd32);
    chk_val("checker_32_0", 32'(vif3.rgb_data), 32'h000000);

    // Asynchronous reset mid-line.
    wait_px3(30, 20, 5000, "wait_midline");
    reset = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) cmp_vo("async_reset", d, get_act(d), idle_px(get_cfg(d)));
    step(2);
    reset = 1'b0;
    step(1);
    chk_val("post_rst_fs", 32'(vif3.frame_start), 32'd1);
    chk_val("post_rst_xy", {vif3.pix_x, vif3.pix_y}, 32'd0);
    chk_val("post_rst_rgb", 32'(vif3.rgb_data), 32'hFFFFFF);
    chk_val("post_rst_fs_def", 32'(vif0.frame_start), 32'd1);

    // Drop run for three cycles mid-frame on the small raster.
    step(40);
    run = 1'b0;
    step(1);
    chk_val("norun_de", 32'(vif2.data_enable), 32'd0);
    chk_val("norun_hsync", 32'(vif2.hsync), 32'd0);
    chk_val("norun_rgb", 32'(vif2.rgb_data), 32'd0);
    step(2);
    run = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (i == 0) chk_val("rerun_fs", 32'(vif2.frame_start), 32'd1);
      de_vec[i] = vif2.data_enable;
      hs_vec[i] = vif2.hsync;
      vs_vec[i] = vif2.vsync;
    end
    chk_val("small_de_wave", 32'(de_vec), 32'h00FF);
    chk_val("small_hs_wave", 32'(hs_vec), 32'h0C00);
    chk_val("small_vs_wave", 32'(vs_vec), 32'h0000);

    // Randomised traffic: pattern changes, run drops and reset pulses.
    for (int k = 0; k < 6000; k++) begin
      int r;
      step(1);
      r = int'($urandom_range(0, 999));
      if (r < 10) pattern_sel = 2'($urandom);
      if (r < 5) solid_rgb = 24'($urandom);
      if (reset) reset = 1'b0;
      else if (r == 999) reset = 1'b1;
      if (!run) begin
        if ($urandom_range(0, 3) == 0) run = 1'b1;
      end else if (r >= 500 && r < 503) begin
        run = 1'b0;
      end
    end
    reset = 1'b0;
    run = 1'b1;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
